rvc_expander: RTL and testbench



---
 rtl/rvc_pkg.sv | 43 ++++
 rtl/rvc_expand_comb.sv | 132 +++++++++++++
 rtl/rvc_expander.sv | 55 +++++
 tb/tb_rvc_expander.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_pkg.sv
// Shared RV32I encoding constants and register-field helper for the RVC expander.
package rvc_pkg;

    localparam int XLEN = 32;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b000_0000;
    localparam logic [6:0] F7_ALT  = 7'b010_0000;

    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [11:0]     IMM_EBREAK   = 12'h001;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd2;

    // Compressed 3-bit register fields address x8..x15.
    function automatic logic [4:0] creg(input logic [2:0] r);
        return {2'b01, r};
    endfunction

endpackage

// File: rtl/rvc_expand_comb.sv
// Pure combinational RV32C -> RV32I expansion; illegal encodings yield a zero word.
module rvc_expand_comb
    import rvc_pkg::*;
(
    input  logic [15:0]     comp_instr,
    output logic [XLEN-1:0] exp_instr,
    output logic            illegal
);

    logic [15:0] c;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rp_hi;
    logic [4:0]  rp_lo;
    logic [5:0]  imm6;
    logic [11:0] imm6_sx;
    logic [19:0] j_imm;
    logic [6:0]  b_hi;
    logic [4:0]  b_lo;

    assign c       = comp_instr;
    assign rd      = c[11:7];
    assign rs2     = c[6:2];
    assign rp_hi   = creg(c[9:7]);
    assign rp_lo   = creg(c[4:2]);
    assign imm6    = {c[12], c[6:2]};
    assign imm6_sx = {{6{c[12]}}, imm6};
    // J-type immediate field {imm[20], imm[10:1], imm[11], imm[19:12]} of the sign-extended offset.
    assign j_imm   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}};
    assign b_hi    = {c[12], c[12], c[12], c[12], c[6:5], c[2]};
    assign b_lo    = {c[11:10], c[4:3], c[12]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases infers a latch.
        exp_instr = '0;
        illegal   = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        if (c[12:5] == 8'd0) illegal = 1'b1;
                        else exp_instr = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00,
                                          REG_SP, F3_ADD, rp_lo, OPC_OP_IMM};
                    end
                    3'b010: exp_instr = {5'b0, c[5], c[12:10], c[6], 2'b00,
                                         rp_hi, F3_W, rp_lo, OPC_LOAD};
                    3'b110: exp_instr = {5'b0, c[5], c[12], rp_lo, rp_hi, F3_W,
                                         c[11:10], c[6], 2'b00, OPC_STORE};
                    default: illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: exp_instr = {imm6_sx, rd, F3_ADD, rd, OPC_OP_IMM};
                    3'b001: exp_instr = {j_imm, REG_RA, OPC_JAL};
                    3'b010: exp_instr = {imm6_sx, REG_ZERO, F3_ADD, rd, OPC_OP_IMM};
                    3'b011: begin
                        if (imm6 == 6'd0) illegal = 1'b1;
                        else if (rd == REG_SP)
                            exp_instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000,
                                         REG_SP, F3_ADD, REG_SP, OPC_OP_IMM};
                        else
                            exp_instr = {{14{c[12]}}, imm6, rd, OPC_LUI};
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                if (c[12]) illegal = 1'b1;
                                else exp_instr = {F7_BASE, c[6:2], rp_hi, F3_SR, rp_hi, OPC_OP_IMM};
                            end
                            2'b01: begin
                                if (c[12]) illegal = 1'b1;
                                else exp_instr = {F7_ALT, c[6:2], rp_hi, F3_SR, rp_hi, OPC_OP_IMM};
                            end
                            2'b10: exp_instr = {imm6_sx, rp_hi, F3_AND, rp_hi, OPC_OP_IMM};
                            default: begin
                                if (c[12]) illegal = 1'b1;
                                else begin
                                    case (c[6:5])
                                        2'b00:   exp_instr = {F7_ALT,  rp_lo, rp_hi, F3_ADD, rp_hi, OPC_OP};
                                        2'b01:   exp_instr = {F7_BASE, rp_lo, rp_hi, F3_XOR, rp_hi, OPC_OP};
                                        2'b10:   exp_instr = {F7_BASE, rp_lo, rp_hi, F3_OR,  rp_hi, OPC_OP};
                                        default: exp_instr = {F7_BASE, rp_lo, rp_hi, F3_AND, rp_hi, OPC_OP};
                                    endcase
                                end
                            end
                        endcase
                    end
                    3'b101: exp_instr = {j_imm, REG_ZERO, OPC_JAL};
                    3'b110: exp_instr = {b_hi, REG_ZERO, rp_hi, F3_BEQ, b_lo, OPC_BRANCH};
                    default: exp_instr = {b_hi, REG_ZERO, rp_hi, F3_BNE, b_lo, OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        if (c[12]) illegal = 1'b1;
                        else exp_instr = {F7_BASE, c[6:2], rd, F3_SLL, rd, OPC_OP_IMM};
                    end
                    3'b010: begin
                        if (rd == REG_ZERO) illegal = 1'b1;
                        else exp_instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                                          REG_SP, F3_W, rd, OPC_LOAD};
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 != REG_ZERO)
                                exp_instr = {F7_BASE, rs2, REG_ZERO, F3_ADD, rd, OPC_OP};
                            else if (rd == REG_ZERO)
                                illegal = 1'b1;
                            else
                                exp_instr = {12'd0, rd, F3_JALR, REG_ZERO, OPC_JALR};
                        end else begin
                            if (rs2 != REG_ZERO)
                                exp_instr = {F7_BASE, rs2, rd, F3_ADD, rd, OPC_OP};
                            else if (rd == REG_ZERO)
                                exp_instr = {IMM_EBREAK, REG_ZERO, 3'b000, REG_ZERO, OPC_SYSTEM};
                            else
                                exp_instr = {12'd0, rd, F3_JALR, REG_RA, OPC_JALR};
                        end
                    end
                    3'b110: exp_instr = {4'b0, c[8:7], c[12], rs2, REG_SP, F3_W,
                                         c[11:9], 2'b00, OPC_STORE};
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) exp_instr = '0;
    end

endmodule

// File: rtl/rvc_expander.sv
// Registered RVC expander: one cycle from valid_in/comp_instr to valid_out/exp_instr/illegal.
module rvc_expander
    import rvc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [15:0]     comp_instr,
    output logic            valid_out,
    output logic [XLEN-1:0] exp_instr,
    output logic            illegal
);

    logic [XLEN-1:0] exp_comb;
    logic            ill_comb;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] exp_q,   exp_d;
    logic            ill_q,   ill_d;

    rvc_expand_comb u_expand (
        .comp_instr (comp_instr),
        .exp_instr  (exp_comb),
        .illegal    (ill_comb)
    );

    // Payload holds its last value while no new instruction is presented.
    always_comb begin
        valid_d = valid_in;
        exp_d   = exp_q;
        ill_d   = ill_q;
        if (valid_in) begin
            exp_d = exp_comb;
            ill_d = ill_comb;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            exp_q   <= INSTR_NOP;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            exp_q   <= exp_d;
            ill_q   <= ill_d;
        end
    end

    assign valid_out = valid_q;
    assign exp_instr = exp_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_rvc_expander.sv
// Directed vectors, multi-cycle sequences and an exhaustive sweep against an RVC reference model.
module tb_rvc_expander;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] comp_instr;
    logic        valid_out;
    logic [31:0] exp_instr;
    logic        illegal;

    int n_cmp;
    int n_bad;

    rvc_expander dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .comp_instr (comp_instr),
        .valid_out  (valid_out),
        .exp_instr  (exp_instr),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        ill;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [19];

    // Compared value is {valid_out, illegal, exp_instr}.
    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got valid=%b illegal=%b instr=%h, required valid=%b illegal=%b instr=%h",
                     name, act[33], act[32], act[31:0], req[33], req[32], req[31:0]);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] instr);
        @(negedge clk);
        valid_in   = v;
        comp_instr = instr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] outs();
        return {valid_out, illegal, exp_instr};
    endfunction

    // Generic RV32I encoders; immediates are passed as full 32-bit values.
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] sx6(input logic [5:0] s);
        return {{26{s[5]}}, s};
    endfunction

    // Reference model written from the RVC instruction tables; returns {illegal, word}.
    function automatic logic [32:0] golden(input logic [15:0] c);
        logic [4:0]  rd, rs2, rp_h, rp_l;
        logic [5:0]  sh;
        logic [31:0] imm, w;
        logic        ill;
        rd = c[11:7]; rs2 = c[6:2];
        rp_h = {2'b01, c[9:7]}; rp_l = {2'b01, c[4:2]};
        sh = {c[12], c[6:2]};
        ill = 1'b0; w = '0; imm = '0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                imm[5:4] = c[12:11]; imm[9:6] = c[10:7]; imm[2] = c[6]; imm[3] = c[5];
                if (imm == 0) ill = 1'b1; else w = enc_i(imm, 5'd2, 3'd0, rp_l, 7'h13);
            end
            5'b00_010, 5'b00_110: begin
                imm[5:3] = c[12:10]; imm[2] = c[6]; imm[6] = c[5];
                if (c[15]) w = enc_s(imm, rp_l, rp_h, 3'd2, 7'h23);
                else       w = enc_i(imm, rp_h, 3'd2, rp_l, 7'h03);
            end
            5'b01_000: w = enc_i(sx6(sh), rd, 3'd0, rd, 7'h13);
            5'b01_010: w = enc_i(sx6(sh), 5'd0, 3'd0, rd, 7'h13);
            5'b01_001, 5'b01_101: begin
                imm[11] = c[12]; imm[4] = c[11]; imm[9:8] = c[10:9]; imm[10] = c[8];
                imm[6] = c[7]; imm[7] = c[6]; imm[3:1] = c[5:3]; imm[5] = c[2];
                imm[31:12] = {20{c[12]}};
                w = enc_j(imm, c[15] ? 5'd0 : 5'd1);
            end
            5'b01_011: begin
                if (rd == 5'd2) begin
                    imm[9] = c[12]; imm[4] = c[6]; imm[6] = c[5]; imm[8:7] = c[4:3]; imm[5] = c[2];
                    if (imm == 0) ill = 1'b1;
                    else begin
                        imm[31:10] = {22{c[12]}};
                        w = enc_i(imm, 5'd2, 3'd0, 5'd2, 7'h13);
                    end
                end else begin
                    imm = sx6(sh) << 12;
                    if (sh == 0) ill = 1'b1; else w = {imm[31:12], rd, 7'h37};
                end
            end
            5'b01_100: begin
                case (c[11:10])
                    2'd0: if (c[12]) ill = 1'b1; else w = enc_r(7'h00, sh[4:0], rp_h, 3'd5, rp_h, 7'h13);
                    2'd1: if (c[12]) ill = 1'b1; else w = enc_r(7'h20, sh[4:0], rp_h, 3'd5, rp_h, 7'h13);
                    2'd2: w = enc_i(sx6(sh), rp_h, 3'd7, rp_h, 7'h13);
                    default: begin
                        if (c[12]) ill = 1'b1;
                        else case (c[6:5])
                            2'd0:    w = enc_r(7'h20, rp_l, rp_h, 3'd0, rp_h, 7'h33);
                            2'd1:    w = enc_r(7'h00, rp_l, rp_h, 3'd4, rp_h, 7'h33);
                            2'd2:    w = enc_r(7'h00, rp_l, rp_h, 3'd6, rp_h, 7'h33);
                            default: w = enc_r(7'h00, rp_l, rp_h, 3'd7, rp_h, 7'h33);
                        endcase
                    end
                endcase
            end
            5'b01_110, 5'b01_111: begin
                imm[8] = c[12]; imm[4:3] = c[11:10]; imm[7:6] = c[6:5]; imm[2:1] = c[4:3]; imm[5] = c[2];
                imm[31:9] = {23{c[12]}};
                w = enc_b(imm, rp_h, c[13] ? 3'd1 : 3'd0);
            end
            5'b10_000: if (c[12]) ill = 1'b1; else w = enc_r(7'h00, sh[4:0], rd, 3'd1, rd, 7'h13);
            5'b10_010: begin
                imm[5] = c[12]; imm[4:2] = c[6:4]; imm[7:6] = c[3:2];
                if (rd == 0) ill = 1'b1; else w = enc_i(imm, 5'd2, 3'd2, rd, 7'h03);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 != 0)     w = enc_r(7'h00, rs2, 5'd0, 3'd0, rd, 7'h33);
                    else if (rd == 0) ill = 1'b1;
                    else              w = enc_i(32'd0, rd, 3'd0, 5'd0, 7'h67);
                end else begin
                    if (rs2 != 0)     w = enc_r(7'h00, rs2, rd, 3'd0, rd, 7'h33);
                    else if (rd == 0) w = 32'h0010_0073;
                    else              w = enc_i(32'd0, rd, 3'd0, 5'd1, 7'h67);
                end
            end
            5'b10_110: begin
                imm[5:2] = c[12:9]; imm[7:6] = c[8:7];
                w = enc_s(imm, rs2, 5'd2, 3'd2, 7'h23);
            end
            default: ill = 1'b1;
        endcase
        if (ill) w = '0;
        return {ill, w};
    endfunction

    initial begin
        logic [32:0] g;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        valid_in = 1'b0;
        comp_instr = 16'h0000;

        vecs[0]  = '{16'h852E, 1'b0, 32'h00B0_0533};  // c.mv x10,x11
        vecs[1]  = '{16'h9002, 1'b0, 32'h0010_0073};  // c.ebreak
        vecs[2]  = '{16'h0000, 1'b1, 32'h0000_0000};
        vecs[3]  = '{16'h0003, 1'b1, 32'h0000_0000};  // quadrant 3
        vecs[4]  = '{16'h9005, 1'b1, 32'h0000_0000};  // c.srli shamt[5]=1
        vecs[5]  = '{16'hA001, 1'b0, 32'h0000_006F};  // c.j 0
        vecs[6]  = '{16'h2001, 1'b0, 32'h0000_00EF};  // c.jal 0
        vecs[7]  = '{16'hC001, 1'b0, 32'h0004_0063};  // c.beqz x8,0
        vecs[8]  = '{16'h6101, 1'b1, 32'h0000_0000};  // c.addi16sp 0
        vecs[9]  = '{16'h6141, 1'b0, 32'h0101_0113};  // c.addi16sp 16
        vecs[10] = '{16'h6085, 1'b0, 32'h0000_10B7};  // c.lui x1,1
        vecs[11] = '{16'h8002, 1'b1, 32'h0000_0000};  // c.jr x0
        vecs[12] = '{16'h8082, 1'b0, 32'h0000_8067};  // c.jr x1
        vecs[13] = '{16'h2000, 1'b1, 32'h0000_0000};  // c.fld
        vecs[14] = '{16'h8C05, 1'b0, 32'h4094_0433};  // c.sub x8,x9
        vecs[15] = '{16'h4002, 1'b1, 32'h0000_0000};  // c.lwsp x0
        vecs[16] = '{16'h0086, 1'b0, 32'h0010_9093};  // c.slli x1,1
        vecs[17] = '{16'hC004, 1'b0, 32'h0094_2023};  // c.sw x9,0(x8)
        vecs[18] = '{16'hFC7D, 1'b0, 32'hFE04_1FE3};  // c.bnez x8,-2

        // Reset, including a cycle where valid_in is asserted during reset.
        step(1'b0, 16'h0000);
        check("reset_c1", outs(), {1'b0, 1'b0, 32'h0000_0013});
        step(1'b1, 16'h0040);
        check("reset_prio", outs(), {1'b0, 1'b0, 32'h0000_0013});
        rst = 1'b0;
        step(1'b0, 16'h0040);
        check("post_reset_hold", outs(), {1'b0, 1'b0, 32'h0000_0013});

        step(1'b1, 16'h0040);
        check("addi4spn", outs(), {1'b1, 1'b0, 32'h0041_0413});
        step(1'b0, 16'h0000);
        check("hold_idle", outs(), {1'b0, 1'b0, 32'h0041_0413});

        step(1'b1, 16'h557D);
        check("b2b_li", outs(), {1'b1, 1'b0, 32'hFFF0_0513});
        step(1'b1, 16'h4082);
        check("b2b_lwsp", outs(), {1'b1, 1'b0, 32'h0001_2083});

        for (int i = 0; i < 19; i++) begin
            step(1'b1, vecs[i].instr);
            check($sformatf("vec%0d_%h", i, vecs[i].instr), outs(), {1'b1, vecs[i].ill, vecs[i].word});
        end

        // Illegal result held across idle cycles, then reset while holding.
        step(1'b1, 16'h0003);
        step(1'b0, 16'h852E);
        check("hold_illegal", outs(), {1'b0, 1'b1, 32'h0000_0000});
        rst = 1'b1;
        step(1'b0, 16'h852E);
        check("reset_mid", outs(), {1'b0, 1'b0, 32'h0000_0013});
        rst = 1'b0;

        for (int i = 0; i < 65536; i++) begin
            step(1'b1, i[15:0]);
            g = golden(i[15:0]);
            check($sformatf("sweep_%h", i[15:0]), outs(), {1'b1, g});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
